// File: rtl/p4_egress_demux.sv
// p4_egress_demux: routes P4 packets to one of two AXIS egress ports or drops them, steered by queued metadata
module p4_egress_demux #(
    parameter int TDATA_NUM_BYTES      = 64,
    parameter int USER_META_DATA_WIDTH = 9,
    parameter int META_FIFO_DEPTH      = 4
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
    input  logic                            user_metadata_in_valid,
    input  logic [TDATA_NUM_BYTES*8-1:0]    s_axis_tdata,
    input  logic [TDATA_NUM_BYTES-1:0]      s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [TDATA_NUM_BYTES*8-1:0]    m0_axis_tdata,
    output logic [TDATA_NUM_BYTES-1:0]      m0_axis_tkeep,
    output logic                            m0_axis_tvalid,
    output logic                            m0_axis_tlast,
    input  logic                            m0_axis_tready,
    output logic [TDATA_NUM_BYTES*8-1:0]    m1_axis_tdata,
    output logic [TDATA_NUM_BYTES-1:0]      m1_axis_tkeep,
    output logic                            m1_axis_tvalid,
    output logic                            m1_axis_tlast,
    input  logic                            m1_axis_tready,
    output logic [31:0]                     pkt_cnt_0,
    output logic [31:0]                     pkt_cnt_1,
    output logic [31:0]                     drop_cnt,
    output logic                            meta_overflow
);

    localparam int AW = $clog2(META_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [31:0] CNT_ONE = 1;

    typedef enum logic {IDLE, FWD} state_t;

    // Only the drop and port bits steer routing, so the FIFO keeps just those two
    logic [1:0]  mem_q [META_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t      state_q, state_d;
    logic        sel_drop_q, sel_drop_d, sel_port_q, sel_port_d;
    logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cntd_q, cntd_d;
    logic        ovf_q, ovf_d;
    logic        empty, full, push, pop, fire, done;
    logic [1:0]  head;
    logic        unused_meta;

    assign unused_meta = ^user_metadata_in;

    // FIFO status and handshake qualifiers; a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        empty = wr_ptr_q == rd_ptr_q;
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
        pop   = (state_q == IDLE) && !empty && s_axis_tvalid;
        push  = user_metadata_in_valid && (!full || pop);
        fire  = (state_q == FWD) && s_axis_tvalid && s_axis_tready;
        done  = fire && s_axis_tlast;
    end

    // Zero-latency steering: selected port mirrors the input stream, dropped packets are sunk
    always_comb begin
        s_axis_tready  = (state_q == FWD) && (sel_drop_q || (sel_port_q ? m1_axis_tready : m0_axis_tready));
        m0_axis_tvalid = (state_q == FWD) && !sel_drop_q && !sel_port_q && s_axis_tvalid;
        m1_axis_tvalid = (state_q == FWD) && !sel_drop_q && sel_port_q && s_axis_tvalid;
        m0_axis_tdata  = s_axis_tdata;
        m0_axis_tkeep  = s_axis_tkeep;
        m0_axis_tlast  = s_axis_tlast;
        m1_axis_tdata  = s_axis_tdata;
        m1_axis_tkeep  = s_axis_tkeep;
        m1_axis_tlast  = s_axis_tlast;
        pkt_cnt_0      = cnt0_q;
        pkt_cnt_1      = cnt1_q;
        drop_cnt       = cntd_q;
        meta_overflow  = ovf_q;
    end

    // Next-state: pointers, packet FSM with latched routing, counters and sticky overflow
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        state_d    = pop ? FWD : (done ? IDLE : state_q);
        sel_drop_d = pop ? head[1] : sel_drop_q;
        sel_port_d = pop ? head[0] : sel_port_q;
        cnt0_d     = cnt0_q + ((done && !sel_drop_q && !sel_port_q) ? CNT_ONE : '0);
        cnt1_d     = cnt1_q + ((done && !sel_drop_q && sel_port_q) ? CNT_ONE : '0);
        cntd_d     = cntd_q + ((done && sel_drop_q) ? CNT_ONE : '0);
        ovf_d      = ovf_q || (user_metadata_in_valid && full && !pop);
    end

    // Metadata storage; contents are meaningless until the write pointer covers them, so no reset
    always_ff @(posedge s_axis_aclk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {user_metadata_in[8], user_metadata_in[0]};
    end

    // All control state; async reset abandons any in-flight packet and empties the FIFO
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            sel_drop_q <= 1'b0;
            sel_port_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            cntd_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            sel_drop_q <= sel_drop_d;
            sel_port_q <= sel_port_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            cntd_q     <= cntd_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: doc/p4_egress_demux.md
P4_EGRESS_DEMUX -- requirements
Module: p4_egress_demux

Interface
REQ-001 The block SHALL have parameter TDATA_NUM_BYTES, default 64, giving the AXIS data width in bytes.
REQ-002 The block SHALL have parameter USER_META_DATA_WIDTH, default 9, giving the P4 metadata width.
REQ-003 The block SHALL have parameter META_FIFO_DEPTH, default 4, giving metadata FIFO entries (power of 2, >=2).
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low; ports s_axis_aclk and s_axis_aresetn.
REQ-005 s_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 s_axis_aresetn  in  1  async active-low reset.
REQ-007 user_metadata_in  in  USER_META_DATA_WIDTH  per-packet metadata from P4 core; bit 8 = drop, bit 0 = egress port.
REQ-008 user_metadata_in_valid  in  1  one-cycle strobe, one per packet, no backpressure.
REQ-009 s_axis_tdata / tkeep / tvalid / tlast  in  TDATA_NUM_BYTES*8 / TDATA_NUM_BYTES / 1 / 1  packet stream from P4 core.
REQ-010 s_axis_tready  out  1  ready to P4 core.
REQ-011 m0_axis_tdata / tkeep / tvalid / tlast  out  same widths  egress port 0; m0_axis_tready in 1.
REQ-012 m1_axis_tdata / tkeep / tvalid / tlast  out  same widths  egress port 1; m1_axis_tready in 1.
REQ-013 pkt_cnt_0, pkt_cnt_1, drop_cnt  out  32 each  packets completed on port 0, port 1, dropped.
REQ-014 meta_overflow  out  1  sticky: metadata strobe arrived with FIFO full.

Function
REQ-015 Metadata FIFO SHALL push user_metadata_in on every cycle user_metadata_in_valid=1 and FIFO not full.
REQ-016 Strobe while full SHALL be discarded and set meta_overflow=1 until reset; a same-cycle pop frees a slot and the push SHALL then succeed.
REQ-017 FSM states SHALL be IDLE and FWD.
REQ-018 IDLE -> FWD when FIFO non-empty and s_axis_tvalid=1; in that cycle pop head entry, latch sel_drop=meta[8], sel_port=meta[0]; s_axis_tready=0 in IDLE.
REQ-019 A packet with no metadata yet SHALL stall in IDLE (tready=0) indefinitely; no timeout.
REQ-020 In FWD, s_axis_tready SHALL equal 1 if sel_drop, else m<sel_port>_axis_tready.
REQ-021 In FWD with sel_drop=0, m<sel_port>_axis_tvalid SHALL equal s_axis_tvalid and tdata/tkeep/tlast SHALL pass through combinationally (zero latency); the unselected port's tvalid SHALL be 0.
REQ-022 In FWD with sel_drop=1, both m*_axis_tvalid SHALL be 0 and beats SHALL be consumed.
REQ-023 Beat with tvalid & tready & tlast in FWD SHALL return FSM to IDLE next cycle and increment exactly one of pkt_cnt_0, pkt_cnt_1, drop_cnt by 1.
REQ-024 Counters SHALL wrap from 2^32-1 to 0 without flag.
REQ-025 Minimum spacing: one IDLE cycle between packets (back-to-back throughput = N beats per N+1 cycles).
REQ-026 m*_axis_tvalid SHALL be 0 in IDLE; data outputs are don't-care when tvalid=0.
REQ-027 Metadata push/pop SHALL be independent of packet FSM stalls.

Reset
REQ-028 On s_axis_aresetn=0 asynchronously: FSM=IDLE, FIFO empty, counters=0, meta_overflow=0, s_axis_tready=0, m0/m1_axis_tvalid=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no counter increments; after release the next beat is treated as a new packet start.
REQ-030 Metadata strobes during reset SHALL be ignored.

Verification
REQ-031 Meta 9'h000 then 3-beat packet, m0_tready=1 -> 3 beats on m0, last with tlast, pkt_cnt_0=1, m1_tvalid never 1.
REQ-032 Meta 9'h001, 1-beat packet, m1_tready held 0 for 5 cycles -> s_axis_tready=0, m1_tvalid=1 stable 5 cycles, then accepted, pkt_cnt_1=1.
REQ-033 Meta 9'h100, 4-beat packet -> tready=1 each FWD cycle, no m*_tvalid, drop_cnt=1.
REQ-034 Packet tvalid asserted 3 cycles before its metadata strobe -> tready=0 until strobe; forwarding starts cycle after FIFO non-empty.
REQ-035 5 strobes without packets (depth 4) -> meta_overflow=1, FIFO holds first 4; then 4 packets route per those 4 entries.
REQ-036 Reset asserted on beat 2 of 4-beat packet -> all outputs/counters zero; next meta+packet routes correctly.
